delay_timer: RTL and testbench
==============================

# delay_timer

Parametrised, multi-mode successor to the single-shot carry-save delay counter. Loads a delay of N cycles and counts enabled clock edges in redundant sum/carry form, so no width-long carry chain exists. It flags expiry either once (one-shot) or every N enabled cycles (periodic auto-reload). It sits beside protocol blocks that need deterministic timeouts or strobes at arbitrary width.

## Interface
- `width`, default 8: count width in bits; legal range 2..64.
- `clk  input  1`: clock; all state updates on the rising edge.
- `rst_n  input  1`: reset, synchronous and active-low; dominates every other input.
- `ld  input  1`: load request; samples `nb` and `mode`.
- `nb  input  width`: delay N in enabled cycles; 0 encodes 2^width.
- `mode  input  1`: sampled with `ld`; 0 selects one-shot, 1 selects periodic.
- `en  input  1`: count enable; low freezes the count.
- `dn  output  1`: done level, registered, sticky until the next `ld` or reset.
- `tick  output  1`: one-cycle expiry strobe, registered; periodic mode only.
- `busy  output  1`: registered; high while a count is in progress.

## Operation
- Count state:
  - Sum register of width-1 bits, carry register of width bits, plus a stored reload value and a mode bit.
  - One increment per enabled edge uses a 2:2 compressor (XOR/AND) plus an inverted LSB carry.
  - Expiry is the carry-out of the MSB, i.e. the counter seeded with -N reaching 2^width.
- Combinational depth from state to next state is constant in `width`. A binary adder on the count path is forbidden.
- Load:
  - `ld`=1 seeds the counter with the encoding of -N, stores N and `mode`.
  - Clears `dn` and `tick`; sets `busy`.
  - Takes effect regardless of `en`.
- States:
  - IDLE (`busy`=0, `dn`=0): after reset.
  - RUN (`busy`=1): counting.
  - DONE (`busy`=0, `dn`=1): one-shot expired.
- Transitions:
  - IDLE→RUN on `ld`.
  - RUN→DONE on expiry in one-shot mode.
  - RUN→RUN on expiry in periodic mode: reload with -N, pulse `tick`, set `dn`.
  - DONE→RUN on `ld`.
  - DONE holds while `ld`=0; `en` is ignored.
- Boundaries:
  - `ld` on the same edge as expiry: load wins; no `tick`, and `dn` stays 0.
  - `ld` during RUN restarts the count from the new N.
  - `en`=0 during RUN holds all state, including the edge where expiry would have occurred.
  - N=0 counts 2^width enabled edges. N=1 expires on the first enabled edge after load.
  - Reset mid-count returns to IDLE with all outputs 0 on the next edge.

## Timing
- Reset values: `dn`=0, `tick`=0, `busy`=0; sum, carry and reload registers are cleared.
- The load edge is E0. With `en` held high, `dn` and `tick` become visible after edge E0+N.
- Periodic mode: `tick` is high after edges E0+kN, k≥1, for exactly one cycle each.
- With gaps in `en`, expiry follows the N-th edge after E0 at which `en`=1. `en` on the E0 edge itself does not count.
- `busy` rises after E0. In one-shot mode it falls after the expiry edge, coincident with `dn` rising.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `DELAY_TIMER_PERIODIC_EN`, defined:
  - Periodic mode, the reload register and `tick` are implemented.
- Undefined:
  - `mode` is ignored and forced to one-shot; `tick` is tied to 0.
  - No reload register exists; the mode bit is optimised away.
  - One-shot behaviour is identical in both builds.

## Test plan
- One-shot: width=5, N=10, `ld` at E0, `en`=1 → `dn`=0 through E0+9, `dn`=1 and `busy`=0 after E0+10, and `dn` holds 1 for a further 20 cycles.
- Periodic (macro defined): width=5, N=3 → `tick` high after E0+3, +6, +9, +12; `dn`=1 from E0+3; `busy` stays 1.
- Enable gaps: N=4, `en` low on edges E0+2 and E0+3 → `dn` rises after E0+6.
- Wrap and extremes: width=5, N=0 → expiry after E0+32; N=1 → expiry after E0+1.
- Collisions: periodic N=5, `ld` with N=2 on edge E0+5 → no `tick` at E0+5, `dn`=0, next `tick` after E0+7. `rst_n`=0 at E0+2 → all outputs 0 after E0+2, and no expiry follows.
- Macro undefined: `mode`=1, N=3 → one-shot behaviour, and `tick` stays 0 throughout.

Source files
------------

// File: rtl/delay_timer.sv
// Delay timer counting enabled edges in carry-save form; one-shot or periodic expiry.
// Optional periodic mode, reload register and tick: define DELAY_TIMER_PERIODIC_EN.
module delay_timer #(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [width-1:0] nb,
   input  logic             mode,
   input  logic             en,
   output logic             dn,
   output logic             tick,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [width-2:0] s_q, s_nxt, seed_s;
   logic [width-1:0] c_q, c_nxt, seed_c, inv_n;
   logic             small_n;
   logic             expire;

   // Column j sees carries one edge after column j-1, so the MSB carry-out
   // lags the true wrap by width-1 enabled edges.
   always_comb begin
      s_nxt    = '0;
      c_nxt    = '0;
      c_nxt[0] = ~c_q[0];
      c_nxt[1] = c_q[0];
      for (int unsigned j = 1; j < width; j++) begin
         s_nxt[j-1] = s_q[j-1] ^ c_q[j];
         if (j < width - 1)
            c_nxt[j+1] = s_q[j-1] & c_q[j];
      end
   end

   assign expire = s_q[width-2] & c_q[width-1];

   // Seed = (width-1) - N, pre-compensating that lag; N in 1..width-1 instead
   // injects one in-flight carry into an all-ones sum row.
   always_comb begin
      small_n = 1'b0;
      seed_s  = '0;
      seed_c  = '0;
      inv_n   = ~nb + width'(width);
      for (int unsigned j = 1; j < width; j++) begin
         if (nb == width'(width - j)) begin
            small_n   = 1'b1;
            seed_c[j] = 1'b1;
         end
      end
      if (small_n) begin
         seed_s = '1;
      end else begin
         seed_c[0] = inv_n[0];
         seed_s    = inv_n[width-1:1];
      end
   end

`ifdef DELAY_TIMER_PERIODIC_EN
   logic [width-2:0] rld_s;
   logic [width-1:0] rld_c;
   logic             per_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rld_s <= '0;
         rld_c <= '0;
         per_q <= 1'b0;
      end else if (ld) begin
         rld_s <= seed_s;
         rld_c <= seed_c;
         per_q <= mode;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || ld)
         tick <= 1'b0;
      else
         tick <= (state == RUN) && en && expire && per_q;
   end
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign tick        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         s_q   <= '0;
         c_q   <= '0;
         dn    <= 1'b0;
         busy  <= 1'b0;
      end else if (ld) begin
         state <= RUN;
         s_q   <= seed_s;
         c_q   <= seed_c;
         dn    <= 1'b0;
         busy  <= 1'b1;
      end else if (state == RUN && en) begin
         if (expire) begin
            dn <= 1'b1;
`ifdef DELAY_TIMER_PERIODIC_EN
            if (per_q) begin
               s_q <= rld_s;
               c_q <= rld_c;
            end else begin
               state <= DONE;
               busy  <= 1'b0;
            end
`else
            state <= DONE;
            busy  <= 1'b0;
`endif
         end else begin
            s_q <= s_nxt;
            c_q <= c_nxt;
         end
      end
   end

endmodule

// File: tb/tb_delay_timer.sv
// Randomised bench for delay_timer (width=5) against a remaining-count reference model.
module tb_delay_timer;

   localparam int unsigned W = 5;
`ifdef DELAY_TIMER_PERIODIC_EN
   localparam bit PER = 1'b1;
`else
   localparam bit PER = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ld = 1'b0;
   logic [W-1:0] nb = '0;
   logic         mode = 1'b0;
   logic         en = 1'b0;
   logic         dn, tick, busy;

   always #5 clk = ~clk;

   delay_timer #(.width(W)) dut (
      .clk(clk), .rst_n(rst_n), .ld(ld), .nb(nb), .mode(mode), .en(en),
      .dn(dn), .tick(tick), .busy(busy)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   bit m_busy, m_dn, m_tick, m_per;
   int m_rem, m_n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive on negedge, advance the model at posedge, compare 1 time unit later.
   task automatic cyc(input logic r, input logic l, input logic [W-1:0] n,
                      input logic m, input logic e);
      @(negedge clk);
      rst_n = r; ld = l; nb = n; mode = m; en = e;
      @(posedge clk);
      if (!r) begin
         m_busy = 0; m_dn = 0; m_tick = 0; m_per = 0; m_rem = 0; m_n = 0;
      end else if (l) begin
         m_n = (n == 0) ? (1 << W) : int'(n);
         m_rem = m_n; m_per = PER && m;
         m_busy = 1; m_dn = 0; m_tick = 0;
      end else begin
         m_tick = 0;
         if (m_busy && e) begin
            m_rem--;
            if (m_rem == 0) begin
               m_dn = 1;
               if (m_per) begin
                  m_tick = 1;
                  m_rem = m_n;
               end else begin
                  m_busy = 0;
               end
            end
         end
      end
      #1;
      check("dn", dn, m_dn);
      check("tick", tick, m_tick);
      check("busy", busy, m_busy);
   endtask

   // Loads N with en held high and measures edges until dn rises (0 if it never does).
   task automatic latency(input string tag, input logic [W-1:0] n, input int exp);
      int k = 0;
      cyc(1, 1, n, 1'b0, 1);
      for (int i = 1; i <= 40 && k == 0; i++) begin
         cyc(1, 0, '0, 1'b0, 1);
         if (dn === 1'b1) k = i;
      end
      check(tag, k, exp);
   endtask

   initial begin
      int tk;
      logic [W-1:0] rn;

      cyc(0, 0, '0, 0, 0);
      cyc(0, 1, 5'd7, 1, 1);
      check("rst_busy", busy, 0);

      // One-shot N=10, then hold DONE for 20 cycles with en toggling.
      cyc(1, 1, 5'd10, 0, 1);
      for (int i = 0; i < 30; i++) cyc(1, 0, '0, 0, 1'(i % 2 == 0 || i < 10));

      latency("lat_n10", 5'd10, 10);
      latency("lat_n0", 5'd0, 32);
      latency("lat_n1", 5'd1, 1);
      latency("lat_n4", 5'd4, 4);
      latency("lat_n5", 5'd5, 5);
      latency("lat_n31", 5'd31, 31);

      // Periodic N=3 (one-shot in the default build): count ticks over 12 edges.
      tk = 0;
      cyc(1, 1, 5'd3, 1, 1);
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0, '0, 1, 1);
         if (tick === 1'b1) tk++;
      end
      check("tick_count", tk, PER ? 4 : 0);

      // Enable gap on E0+2 and E0+3.
      cyc(1, 1, 5'd4, 0, 1);
      cyc(1, 0, '0, 0, 1);
      cyc(1, 0, '0, 0, 0);
      cyc(1, 0, '0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, 1);

      // Load colliding with expiry, then reset mid-count.
      cyc(1, 1, 5'd5, 1, 1);
      for (int i = 0; i < 4; i++) cyc(1, 0, '0, 1, 1);
      cyc(1, 1, 5'd2, 1, 1);
      check("coll_dn", dn, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, '0, 1, 1);
      cyc(1, 1, 5'd4, 0, 1);
      cyc(1, 0, '0, 0, 1);
      cyc(0, 0, '0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, 0, '0, 0, 1);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         rn = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5)) : W'($urandom_range(0, 15));
         cyc(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 19) == 0), rn,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
